imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC, LEN, LEN*4 LE data bytes, XOR CKS.
// Ports: rx byte stream in; imem write port, core reset, done/error out.
module imem_loader #(
    parameter int         N          = 32,
    parameter int         IMEM_DEPTH = 76,
    parameter logic [7:0] MAGIC      = 8'hA5
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic         o_imem_we,
    output logic [N-1:0] o_imem_addr,
    output logic [N-1:0] o_imem_wdata,
    output logic         o_cpu_rst_n,
    output logic         o_done,
    output logic         o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] cnt;
    logic [15:0] widx;
    logic [1:0]  bidx;
    logic [7:0]  cks;
    logic [23:0] sh;

    logic        acc;
    logic        is_magic;
    logic [15:0] len_full;

    assign acc      = i_rx_valid & o_rx_ready;
    assign is_magic = (i_rx_data == MAGIC);
    assign len_full = {i_rx_data, len_lo};

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state        <= S_IDLE;
            len_lo       <= '0;
            cnt          <= '0;
            widx         <= '0;
            bidx         <= '0;
            cks          <= '0;
            sh           <= '0;
            o_rx_ready   <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_cpu_rst_n  <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_rx_ready <= 1'b1;
            o_imem_we  <= 1'b0;
            if (acc) begin
                unique case (state)
                    S_IDLE: begin
                        if (is_magic)
                            state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_lo <= i_rx_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        cnt  <= len_full;
                        widx <= '0;
                        bidx <= '0;
                        cks  <= '0;
                        if (32'(len_full) > IMEM_DEPTH) begin
                            state   <= S_ERROR;
                            o_error <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // First byte ends up in the low lane after 3 shifts.
                        cks  <= cks ^ i_rx_data;
                        sh   <= {i_rx_data, sh[23:8]};
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            o_imem_we    <= 1'b1;
                            o_imem_addr  <= N'({widx, 2'b00});
                            o_imem_wdata <= N'({i_rx_data, sh});
                            widx         <= widx + 16'd1;
                            if (widx + 16'd1 == cnt)
                                state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (i_rx_data == cks) begin
                            state       <= S_DONE;
                            o_done      <= 1'b1;
                            o_cpu_rst_n <= 1'b1;
                        end else begin
                            state   <= S_ERROR;
                            o_error <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (is_magic) begin
                            state       <= S_LEN_LO;
                            o_done      <= 1'b0;
                            o_cpu_rst_n <= 1'b0;
                        end
                    end
                    S_ERROR: begin
                        if (is_magic) begin
                            state   <= S_LEN_LO;
                            o_error <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scoreboard of expected imem writes
// plus directed status checks.
module tb_imem_loader;

    logic        clk;
    logic        arst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  fr[$];

    imem_loader #(
        .N(32),
        .IMEM_DEPTH(76),
        .MAGIC(8'hA5)
    ) dut (
        .i_clk(clk),
        .i_arst_n(arst_n),
        .i_rx_data(rx_data),
        .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready),
        .o_imem_we(we),
        .o_imem_addr(addr),
        .o_imem_wdata(wdata),
        .o_cpu_rst_n(cpu_rst_n),
        .o_done(done),
        .o_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe pops one expected write.
    always @(negedge clk) begin
        if (done && error) begin
            checks++;
            errors++;
            $display("FAIL done_and_error: both 1 expected not both");
        end
        if (we === 1'b1) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h expected none",
                         addr, wdata);
            end else begin
                automatic logic [31:0] ea = exp_addr.pop_front();
                automatic logic [31:0] ed = exp_data.pop_front();
                if (addr !== ea || wdata !== ed) begin
                    errors++;
                    $display("FAIL write: got %h@%h expected %h@%h",
                             wdata, addr, ed, ea);
                end
            end
        end
    end

    task automatic expect_w(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Gaps drive MAGIC with valid low to prove it is ignored.
    task automatic send_fr(input bit gaps);
        foreach (fr[i]) begin
            send_byte(fr[i]);
            if (gaps) begin
                automatic int n = $urandom_range(0, 3);
                rx_data = 8'hA5;
                repeat (n) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic push_good;
        expect_w(32'h0, 32'h0000_0013);
        expect_w(32'h4, 32'h0010_0093);
    endtask

    task automatic chk_status(input string n,
                              input logic d,
                              input logic e,
                              input logic c);
        chk({n, "_done"}, {31'b0, done}, {31'b0, d});
        chk({n, "_error"}, {31'b0, error}, {31'b0, e});
        chk({n, "_cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, c});
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_ready"}, {31'b0, rx_ready}, 32'h0);
        chk({n, "_we"}, {31'b0, we}, 32'h0);
        chk({n, "_addr"}, addr, 32'h0);
        chk({n, "_wdata"}, wdata, 32'h0);
        chk_status(n, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        arst_n   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", {31'b0, rx_ready}, 32'h1);

        // Good 2-word frame.
        push_good();
        fr = '{8'hA5, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00};
        send_fr(0);
        chk_status("pre_cks", 1'b0, 1'b0, 1'b0);
        send_byte(8'h90);
        chk_status("good", 1'b1, 1'b0, 1'b1);

        // Bad checksum: writes still happen, then error.
        push_good();
        fr = '{8'hA5, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        send_fr(0);
        chk_status("bad_cks", 1'b0, 1'b1, 1'b0);

        // Resend good frame.
        push_good();
        fr = '{8'hA5, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_fr(0);
        chk_status("resend", 1'b1, 1'b0, 1'b1);

        // Over-length count 77: error on LEN_HI, data ignored.
        fr = '{8'hA5, 8'h4D, 8'h00};
        send_fr(0);
        chk_status("overlen", 1'b0, 1'b1, 1'b0);
        fr = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h90};
        send_fr(0);
        chk_status("overlen_tail", 1'b0, 1'b1, 1'b0);

        // Empty frame.
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_fr(0);
        chk_status("empty", 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5);
        chk_status("restart", 1'b0, 1'b0, 1'b0);
        push_good();
        fr = '{8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_fr(0);
        chk_status("after_restart", 1'b1, 1'b0, 1'b1);

        // Reset after 6 data bytes: only word 0 written.
        expect_w(32'h0, 32'h0000_0013);
        fr = '{8'hA5, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00};
        send_fr(0);
        #2;
        arst_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Garbage in IDLE, then good frame with random gaps.
        push_good();
        fr = '{8'h00, 8'hFF, 8'h5A,
               8'hA5, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_fr(1);
        chk_status("gaps", 1'b1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_addr.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
